// File: rtl/led_scan_scheduler.sv
// led_scan_scheduler: time-multiplexed LED sweep scheduler.
// An IDLE/RUN/HOLD FSM accepts a 10-bit game state, then sweeps led_sel
// through FRAMES frames of TICK_DIV cycles each. A new state is only taken
// on the last cycle of a sweep so the decoder never sees a torn frame set.
// pause in RUN freezes the counters on that same edge and moves to HOLD.
// Optional feature macro: LED_BLINK_EN (sweep-parity blanking output).
module led_scan_scheduler #(
  parameter int TICK_DIV = 250,
  parameter int FRAMES   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       st_valid,
  input  logic [9:0] st_data,
  output logic       st_ready,
  input  logic       pause,
  output logic [9:0] led_state,
  output logic [2:0] led_sel,
  output logic       frame_tick,
  output logic       busy,
  output logic       blank
);

  localparam logic [15:0] PC_LAST  = 16'(TICK_DIV - 1);
  localparam logic [2:0]  SEL_LAST = 3'(FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t      r_state, w_nxt;
  logic [15:0] r_pcnt;
  logic [2:0]  r_sel;
  logic [9:0]  r_led;
  logic        w_pc_last, w_sweep_end, w_xfer;

  assign w_pc_last   = (r_pcnt == PC_LAST);
  assign w_sweep_end = w_pc_last && (r_sel == SEL_LAST);
  assign w_xfer      = st_valid && st_ready;
  assign led_state   = r_led;
  assign led_sel     = r_sel;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next state and handshake/tick outputs; clear overrides everything.
  // A paused RUN cycle is treated as already frozen, so no tick or ready.
  always_comb begin
    w_nxt      = r_state;
    st_ready   = 1'b0;
    frame_tick = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        st_ready = 1'b1;
        if (st_valid) w_nxt = S_RUN;
      end
      S_RUN: begin
        if (pause) begin
          w_nxt = S_HOLD;
        end else begin
          frame_tick = w_pc_last;
          st_ready   = w_sweep_end;
        end
      end
      S_HOLD: begin
        if (!pause) w_nxt = S_RUN;
      end
      default: w_nxt = S_IDLE;
    endcase
    if (clear) begin
      st_ready = 1'b0;
      w_nxt    = S_IDLE;
    end
  end

  // Prescaler, frame index and latched state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_sel  <= '0;
      r_led  <= '0;
    end else if (clear) begin
      r_pcnt <= '0;
      r_sel  <= '0;
      r_led  <= '0;
    end else if (r_state == S_IDLE) begin
      r_pcnt <= '0;
      r_sel  <= '0;
      if (w_xfer) r_led <= st_data;
    end else if (r_state == S_RUN && !pause) begin
      r_pcnt <= w_pc_last ? '0 : r_pcnt + 16'd1;
      if (w_pc_last) r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + 3'd1;
      if (w_xfer) r_led <= st_data;
    end
  end

`ifdef LED_BLINK_EN
  logic r_par;

  // Sweep parity: flips at each sweep wrap, cleared by a new state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_par <= 1'b0;
    else if (clear || w_xfer)                       r_par <= 1'b0;
    else if (r_state == S_RUN && !pause && w_sweep_end) r_par <= ~r_par;
  end

  assign blank = r_par && (r_state != S_IDLE);
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Self-checking bench for led_scan_scheduler (TICK_DIV=4, FRAMES=3).
// Directed vector table, hand sequences for pause/clear/reset/blink, then
// random stimulus against a position-in-sweep reference model.
module tb_led_scan_scheduler;
  localparam int TD = 4;
  localparam int FR = 3;
  localparam int SW = TD * FR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0, st_valid = 1'b0, pause = 1'b0;
  logic [9:0] st_data = '0;
  logic       st_ready, frame_tick, busy, blank;
  logic [9:0] led_state;
  logic [2:0] led_sel;

  always #5 clk = ~clk;

  led_scan_scheduler #(.TICK_DIV(TD), .FRAMES(FR)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .st_valid(st_valid),
    .st_data(st_data), .st_ready(st_ready), .pause(pause),
    .led_state(led_state), .led_sel(led_sel), .frame_tick(frame_tick),
    .busy(busy), .blank(blank));

  int n_chk = 0;
  int n_err = 0;

  // Reference model: mode 0=idle 1=run 2=hold, pos = cycle within sweep
  int         m_mode = 0;
  int         m_pos  = 0;
  logic [9:0] m_led  = '0;
  bit         m_par  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !clear && (m_mode == 0 || (m_mode == 1 && !pause && m_pos == SW - 1));
  endfunction

  task automatic check_model(input string nm);
    bit e_blank;
`ifdef LED_BLINK_EN
    e_blank = m_par && (m_mode != 0);
`else
    e_blank = 1'b0;
`endif
    chk({nm, "_sel"},   32'(led_sel),    32'((m_mode == 0) ? 0 : m_pos / TD));
    chk({nm, "_tick"},  32'(frame_tick), 32'(m_mode == 1 && !pause && (m_pos % TD) == TD - 1));
    chk({nm, "_ready"}, 32'(st_ready),   32'(m_ready()));
    chk({nm, "_busy"},  32'(busy),       32'(m_mode != 0));
    chk({nm, "_state"}, 32'(led_state),  32'(m_led));
    chk({nm, "_blank"}, 32'(blank),      32'(e_blank));
  endtask

  task automatic model_edge();
    bit xfer;
    xfer = st_valid && m_ready();
    if (!rst_n || clear) begin
      m_mode = 0; m_pos = 0; m_led = '0; m_par = 1'b0;
    end else if (m_mode == 0) begin
      if (xfer) begin m_led = st_data; m_mode = 1; m_pos = 0; m_par = 1'b0; end
    end else if (m_mode == 1) begin
      if (pause) m_mode = 2;
      else if (m_pos == SW - 1) begin
        m_pos = 0;
        if (xfer) begin m_led = st_data; m_par = 1'b0; end
        else m_par = ~m_par;
      end else m_pos++;
    end else if (!pause) m_mode = 1;
  endtask

  task automatic drive(input bit c, input bit v, input logic [9:0] d, input bit p);
    clear = c; st_valid = v; st_data = d; pause = p;
    #1;
  endtask

  task automatic tick_edge();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit clr; bit vld; bit pau; logic [9:0] dat;
    bit rdy; int sel; bit tck; bit bsy; logic [9:0] led;
  } vec_t;

  vec_t tbl[26];
  int   sel_seq[12]  = '{0,0,0,0,1,1,1,1,2,2,2,2};
  bit   tick_seq[12] = '{0,0,0,1,0,0,0,1,0,0,0,1};
`ifdef LED_BLINK_EN
  bit   blank_exp[4] = '{0,1,0,0};
`else
  bit   blank_exp[4] = '{0,0,0,0};
`endif

  initial begin
    // Row 0: accept 2A5 in IDLE; rows 1..25: RUN cycles 1..25.
    // Second sweep (rows 13..24) offers 155, taken only on row 24.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 10'h2A5, 1'b1, 0, 1'b0, 1'b0, 10'h000};
    for (int k = 1; k < 26; k++) begin
      int i;
      i = (k - 1) % SW;
      tbl[k] = '{1'b0, (k >= 13 && k <= 24), 1'b0, 10'h155,
                 (i == SW - 1), sel_seq[i], tick_seq[i], 1'b1,
                 (k <= 24) ? 10'h2A5 : 10'h155};
    end

    // Reset state, no clock edge yet
    #1;
    chk("rst_sel", 32'(led_sel), 0);
    chk("rst_state", 32'(led_state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(st_ready), 1);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_blank", 32'(blank), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;

    // Table: first accept and sweep-boundary update
    for (int k = 0; k < 26; k++) begin
      drive(tbl[k].clr, tbl[k].vld, tbl[k].dat, tbl[k].pau);
      chk("tbl_ready", 32'(st_ready), 32'(tbl[k].rdy));
      chk("tbl_sel", 32'(led_sel), 32'(tbl[k].sel));
      chk("tbl_tick", 32'(frame_tick), 32'(tbl[k].tck));
      chk("tbl_busy", 32'(busy), 32'(tbl[k].bsy));
      chk("tbl_state", 32'(led_state), 32'(tbl[k].led));
      check_model("tbl");
      tick_edge();
    end

    // Pause at led_sel=1, pcnt=2 (sweep position 6); model is at pos 1
    for (int k = 0; k < 5; k++) begin drive(0, 0, '0, 0); check_model("adv"); tick_edge(); end
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, '0, 1);
      chk("pause_sel", 32'(led_sel), 1);
      chk("pause_tick", 32'(frame_tick), 0);
      chk("pause_ready", 32'(st_ready), 0);
      check_model("pause");
      tick_edge();
    end
    drive(0, 0, '0, 0);
    chk("release_tick", 32'(frame_tick), 0);
    tick_edge();
    drive(0, 0, '0, 0);
    chk("resume1_tick", 32'(frame_tick), 0);
    chk("resume1_sel", 32'(led_sel), 1);
    tick_edge();
    drive(0, 0, '0, 0);
    chk("resume2_tick", 32'(frame_tick), 1);
    check_model("resume2");
    tick_edge();

    // Clear on the end-of-sweep cycle beats a pending transfer (pos 8 now)
    for (int k = 0; k < 3; k++) begin drive(0, 0, '0, 0); tick_edge(); end
    drive(1, 1, 10'h3FF, 0);
    chk("clr_ready", 32'(st_ready), 0);
    chk("clr_sel_pre", 32'(led_sel), 2);
    tick_edge();
    drive(0, 0, '0, 0);
    chk("clr_state", 32'(led_state), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_sel", 32'(led_sel), 0);
    chk("clr_ready_idle", 32'(st_ready), 1);

    // Blink parity over four sweeps; transfer at end of sweep 3 clears it
    drive(0, 1, 10'h0AA, 0);
    tick_edge();
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < SW; i++) begin
        drive(0, (s == 2 && i == SW - 1), 10'h0F0, 0);
        chk("blank_sweep", 32'(blank), 32'(blank_exp[s]));
        check_model("blink");
        tick_edge();
      end
    end
    drive(0, 0, '0, 0);
    chk("blink_new_state", 32'(led_state), 32'h0F0);

    // Random stimulus against the model
    for (int n = 0; n < 800; n++) begin
      drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
            10'($urandom), ($urandom_range(0, 5) == 0));
      check_model("rnd");
      tick_edge();
    end

    // Asynchronous reset mid-RUN: takes effect without a clock edge
    drive(1, 0, '0, 0); tick_edge();
    drive(0, 1, 10'h3C3, 0); tick_edge();
    for (int k = 0; k < 6; k++) begin drive(0, 0, '0, 0); tick_edge(); end
    drive(0, 0, '0, 0);
    chk("pre_arst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(led_sel), 0);
    chk("arst_state", 32'(led_state), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(st_ready), 1);
    tick_edge();
    rst_n = 1'b1;
    #1;
    check_model("post_arst");
    drive(0, 1, 10'h011, 0); tick_edge();
    drive(0, 0, '0, 0);
    check_model("post_arst_run");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/led_scan_scheduler.md
LED_SCAN_SCHEDULER -- requirements
Module: led_scan_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250: clock cycles per frame, legal range 2..65535.
REQ-002 SHALL have parameter FRAMES, default 8: led_sel values per sweep, legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port clear, input, 1 bit: synchronous return to IDLE.
REQ-006 SHALL have port st_valid, input, 1 bit: new game state offered.
REQ-007 SHALL have port st_data, input, 10 bits: offered game state.
REQ-008 SHALL have port st_ready, output, 1 bit: scheduler accepts st_data this cycle.
REQ-009 SHALL have port pause, input, 1 bit: freeze sweep.
REQ-010 SHALL have port led_state, output, 10 bits: latched state driven to the LED decoder.
REQ-011 SHALL have port led_sel, output, 3 bits: current frame index driven to the LED decoder.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse on the last cycle of each frame.
REQ-013 SHALL have port busy, output, 1 bit: high when FSM is not IDLE.
REQ-014 SHALL have port blank, output, 1 bit: LED blanking request (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, RUN and HOLD, plus a prescaler pcnt (0..TICK_DIV-1) and frame counter led_sel.
REQ-016 SHALL define handshake as transfer = st_valid & st_ready, sampled on the rising edge.
REQ-017 In IDLE, SHALL drive st_ready=1, led_sel=0 and pcnt=0.
REQ-018 In IDLE, on transfer SHALL latch st_data into led_state, enter RUN, and clear pcnt and led_sel at the same edge.
REQ-019 In RUN, pcnt SHALL increment each cycle and wrap from TICK_DIV-1 to 0.
REQ-020 frame_tick SHALL be combinationally high only in RUN when pcnt==TICK_DIV-1.
REQ-021 On a frame_tick edge, led_sel SHALL increment, wrapping from FRAMES-1 to 0, so that each led_sel value is held exactly TICK_DIV cycles.
REQ-022 In RUN, st_ready SHALL be 1 only on the last cycle of a sweep (led_sel==FRAMES-1 and pcnt==TICK_DIV-1).
REQ-023 On a transfer at that point, SHALL update led_state; led_sel SHALL wrap to 0 as normal.
REQ-024 Without a transfer at that point, led_state SHALL be retained and the sweep SHALL repeat.
REQ-025 In RUN, pause=1 SHALL enter HOLD at the next edge.
REQ-026 In HOLD, pcnt, led_sel and led_state SHALL be frozen, and st_ready and frame_tick SHALL be 0.
REQ-027 In HOLD, pause=0 SHALL return to RUN, resuming at the frozen count.
REQ-028 pause SHALL be ignored in IDLE.
REQ-029 If pause=1 coincides with the end-of-sweep cycle, pause SHALL take priority: st_ready=0 and no transfer.
REQ-030 clear=1 SHALL force st_ready=0 combinationally and, at the edge, set IDLE, led_state=0, led_sel=0 and pcnt=0.
REQ-031 clear SHALL take priority over transfer and pause in the same cycle.
REQ-032 When FRAMES==1, led_sel SHALL remain 0 and st_ready SHALL pulse once every TICK_DIV cycles in RUN.

Reset
REQ-033 While rst_n=0, SHALL hold FSM=IDLE, led_state=0, led_sel=0, pcnt=0, frame_tick=0, busy=0, blank=0 and st_ready=1, independent of clk.
REQ-034 Deassertion of rst_n SHALL take effect without glitching outputs.
REQ-035 Reset asserted mid-sweep SHALL discard all progress.

Configuration
REQ-036 With LED_BLINK_EN defined, SHALL include a 1-bit sweep-parity register.
REQ-037 With LED_BLINK_EN defined, the parity SHALL toggle at every sweep wrap (led_sel FRAMES-1 -> 0) in RUN.
REQ-038 With LED_BLINK_EN defined, the parity SHALL be cleared on any transfer, clear or reset.
REQ-039 With LED_BLINK_EN defined, blank SHALL equal the parity in RUN and HOLD, and 0 in IDLE.
REQ-040 Without LED_BLINK_EN, blank SHALL be constant 0 and no parity register SHALL be synthesized.

Verification (TICK_DIV=4, FRAMES=3)
REQ-041 SHALL test reset: rst_n=0 mid-RUN -> led_sel=0, led_state=0, busy=0 and st_ready=1 immediately, without a clock edge.
REQ-042 SHALL test the first accept: st_data=10'h2A5 with st_valid=1 in IDLE -> next cycle led_state=10'h2A5, busy=1, led_sel sequence 0,0,0,0,1,1,1,1,2,2,2,2,0, and frame_tick high on cycles 4, 8 and 12.
REQ-043 SHALL test the sweep boundary: st_valid held high with st_data=10'h155 -> st_ready high only on the 12th RUN cycle; led_state becomes 10'h155 at that edge and led_sel returns to 0.
REQ-044 SHALL test pause: pause=1 for 5 cycles at led_sel=1, pcnt=2 -> values frozen, frame_tick=0 and st_ready=0 throughout; after release, 2 more cycles to frame_tick.
REQ-045 SHALL test clear priority: clear=1 with st_valid=1 on the end-of-sweep cycle -> no transfer, led_state=0 and IDLE next cycle.
REQ-046 SHALL test blink with LED_BLINK_EN: blank = 0, 1, 0 over three consecutive sweeps; a new transfer forces blank=0; without the macro, blank stays 0.
